move_entry: RTL
===============

MOVE_ENTRY -- requirements
Module: move_entry

Interface
REQ-001 Parameter DEBOUNCE, default 4, number of consecutive synchronized clock samples a button level must hold before it is accepted; legal range 1..1023.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset_L  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 enterBtn_L  input  1  raw asynchronous enter pushbutton, active-low.
REQ-005 newGameBtn_L  input  1  raw asynchronous new-game pushbutton, active-low.
REQ-006 hMoveSw  input  4  raw switch value of the human move; quasi-static.
REQ-007 taken  input  9  taken[i-1]=1 means square i is already occupied; driven by the downstream game FSM.
REQ-008 busy  input  1  when high, the game FSM cannot accept a human move (computer turn, win display).
REQ-009 hMove  output  4  registered, validated human move presented to the game FSM.
REQ-010 enter_L  output  1  active-low, single-cycle move strobe to the game FSM.
REQ-011 newGame_L  output  1  active-low, single-cycle new-game strobe to the game FSM.
REQ-012 badMove  output  1  active-high, single-cycle rejection strobe for a status LED.

Function
REQ-013 Each raw button passes through a two-flop synchronizer before any other logic reads it.
REQ-014 Each button has an independent debounce FSM with states UP, DOWN_CNT, DOWN and UP_CNT.
REQ-015 UP -> DOWN_CNT when the synchronized level is low; in DOWN_CNT the FSM goes to DOWN after DEBOUNCE consecutive low samples, or back to UP on any high sample, which also clears the counter.
REQ-016 DOWN -> UP_CNT when the synchronized level is high; in UP_CNT the FSM goes to UP after DEBOUNCE consecutive high samples, or back to DOWN on any low sample.
REQ-017 Each button generates exactly one press event, in the cycle of the DOWN_CNT -> DOWN transition; holding the button or bouncing on release generates no further events.
REQ-018 Latency: with the raw input held low, the strobe is driven on the output exactly DEBOUNCE+3 rising edges after the first edge that samples it low.
REQ-019 An enter press event samples hMoveSw in the event cycle.
REQ-020 Accept an enter press when busy=0, 1<=hMoveSw<=9 and taken[hMoveSw-1]=0: hMove<=hMoveSw and enter_L is driven low for exactly one cycle, in the same cycle as the updated hMove.
REQ-021 Reject an enter press when busy=0 and hMoveSw is 0, 10-15 or an occupied square: badMove is driven high for one cycle and hMove is unchanged.
REQ-022 An enter press while busy=1 is discarded: no strobe is issued, badMove stays 0 and hMove is unchanged; discarded presses are not queued.
REQ-023 A new-game press drives newGame_L low for one cycle regardless of busy, and clears hMove to 0 in the same cycle.
REQ-024 If enter and new-game press events occur in the same cycle, new-game wins and the enter event is discarded with no badMove.
REQ-025 enter_L, newGame_L and badMove are never active in the same cycle; hMove holds its value between accepted moves.
REQ-026 The taken range check uses 4-bit unsigned compare; out-of-range values never index taken.

Reset
REQ-027 While reset_L=0 at a rising edge: hMove=0, enter_L=1, newGame_L=1, badMove=0, both debounce FSMs go to UP with counters 0, and synchronizer flops are set to 1.
REQ-028 A button held down through the release of reset produces exactly one press event, after DEBOUNCE+3 edges, counted from the first edge with reset_L=1.
REQ-029 Reset asserted mid-debounce or mid-strobe aborts the operation; no strobe appears in the cycle after reset is released.

Verification (DEBOUNCE=4)
REQ-030 Accept: hMoveSw=6, taken=0, busy=0, enterBtn_L low for 20 cycles -> exactly one enter_L low pulse, 7 edges after the press, hMove=6 in that cycle and after.
REQ-031 Bounce: enterBtn_L toggles every 2 cycles for 10 cycles then holds low -> exactly one pulse, 7 edges after the stable low begins; release bounce -> no pulse.
REQ-032 Reject: hMoveSw=5, taken[4]=1 -> badMove single-cycle pulse, enter_L stays 1, hMove keeps its prior value; repeat with hMoveSw=0 and hMoveSw=12.
REQ-033 Busy: busy=1 during the enter press event -> no enter_L, no badMove; the later release of busy generates no pulse.
REQ-034 Simultaneous: both buttons pressed on the same edge with a valid move -> newGame_L pulses once, enter_L stays 1, hMove=0.
REQ-035 Reset: reset_L low for 1 cycle at the third cycle of a press -> all outputs at reset values; the held button yields one pulse 7 edges after reset release.

Source files
------------

// File: rtl/move_entry.sv
// move_entry: debounced human-move entry for the tic-tac-toe game FSM.
//   Two raw active-low pushbuttons are synchronized and debounced; an enter
//   press validates the switch value against the occupied-square map and
//   either presents it as the next move or flags a bad move.
// Ports:
//   clock, reset_L      system clock, synchronous active-low reset
//   enterBtn_L          raw enter pushbutton (active-low, asynchronous)
//   newGameBtn_L        raw new-game pushbutton (active-low, asynchronous)
//   hMoveSw[3:0]        raw move switches (quasi-static)
//   taken[8:0]          taken[i-1]=1 -> square i occupied
//   busy                game FSM cannot take a human move
//   hMove[3:0]          registered validated move
//   enter_L             one-cycle active-low move strobe
//   newGame_L           one-cycle active-low new-game strobe
//   badMove             one-cycle active-high rejection strobe

// Debounce for one button.
// state    | meaning
// UP       | released and stable
// DOWN_CNT | low seen, counting consecutive low samples
// DOWN     | pressed and stable
// UP_CNT   | high seen, counting consecutive high samples
module move_entry_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clock,
  input  logic reset_L,
  input  logic btn_L,
  output logic press
);

  typedef enum logic [1:0] {UP, DOWN_CNT, DOWN, UP_CNT} state_t;

  // Counter is a down-counter loaded on entry to a counting state; the
  // terminal count (0) on the last required sample completes the transition.
  localparam logic [9:0] LAST = 10'(DEBOUNCE - 1);

  state_t     state;
  logic [9:0] cnt;
  logic       sync_a;
  logic       sync_b;

  // Event in the cycle whose edge moves DOWN_CNT -> DOWN.
  assign press = (state == DOWN_CNT) && !sync_b && (cnt == '0);

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      state  <= UP;
      cnt    <= '0;
    end else begin
      sync_a <= btn_L;
      sync_b <= sync_a;
      case (state)
        UP: begin
          if (!sync_b) begin
            state <= DOWN_CNT;
            cnt   <= LAST;
          end
        end
        DOWN_CNT: begin
          if (sync_b) begin
            state <= UP;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state <= DOWN;
          end else begin
            cnt <= cnt - 10'd1;
          end
        end
        DOWN: begin
          if (sync_b) begin
            state <= UP_CNT;
            cnt   <= LAST;
          end
        end
        UP_CNT: begin
          if (!sync_b) begin
            state <= DOWN;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state <= UP;
          end else begin
            cnt <= cnt - 10'd1;
          end
        end
        default: begin
          state <= UP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

module move_entry #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       enterBtn_L,
  input  logic       newGameBtn_L,
  input  logic [3:0] hMoveSw,
  input  logic [8:0] taken,
  input  logic       busy,
  output logic [3:0] hMove,
  output logic       enter_L,
  output logic       newGame_L,
  output logic       badMove
);

  logic        enter_press;
  logic        new_game_press;
  logic        in_range;
  logic        occupied;
  logic [15:0] taken_ext;

  move_entry_debounce #(.DEBOUNCE(DEBOUNCE)) u_enter_db (
    .clock   (clock),
    .reset_L (reset_L),
    .btn_L   (enterBtn_L),
    .press   (enter_press)
  );

  move_entry_debounce #(.DEBOUNCE(DEBOUNCE)) u_new_game_db (
    .clock   (clock),
    .reset_L (reset_L),
    .btn_L   (newGameBtn_L),
    .press   (new_game_press)
  );

  // Square i sits at bit i of a 16-entry map so every 4-bit switch value
  // indexes a real bit; 0 and 10..15 read as don't-care and are masked by
  // the range check.
  assign taken_ext = {6'b0, taken, 1'b0};
  assign in_range  = (hMoveSw >= 4'd1) && (hMoveSw <= 4'd9);
  assign occupied  = taken_ext[hMoveSw];

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      hMove     <= 4'd0;
      enter_L   <= 1'b1;
      newGame_L <= 1'b1;
      badMove   <= 1'b0;
    end else begin
      enter_L   <= 1'b1;
      newGame_L <= 1'b1;
      badMove   <= 1'b0;
      // New game takes priority and swallows a coincident enter press.
      if (new_game_press) begin
        newGame_L <= 1'b0;
        hMove     <= 4'd0;
      end else if (enter_press && !busy) begin
        if (in_range && !occupied) begin
          hMove   <= hMoveSw;
          enter_L <= 1'b0;
        end else begin
          badMove <= 1'b1;
        end
      end
    end
  end

endmodule
